// File: rtl/race_pkg.sv
//------------------------------------------------------------------------------
// Module   : race_pkg
// Purpose  : Constants shared by the game controller and the VGA renderer.
//            Also holds the game-state encoding and the lane-respawn lookup.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package race_pkg;

  localparam logic [9:0] LANE_L   = 10'd197;
  localparam logic [9:0] LANE_C   = 10'd279;
  localparam logic [9:0] LANE_R   = 10'd361;
  localparam logic [9:0] PLAYER_Y = 10'd357;
  localparam logic [9:0] CAR_H    = 10'd121;
  localparam logic [9:0] CAR_W    = 10'd80;
  localparam logic [9:0] SCREEN_H = 10'd480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2
  } race_state_t;

  // Code 2'b11 folds onto the left lane so the mapping stays total.
  function automatic logic [9:0] lane_from_rand(input logic [1:0] sel);
    case (sel)
      2'b01:   lane_from_rand = LANE_C;
      2'b10:   lane_from_rand = LANE_R;
      default: lane_from_rand = LANE_L;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/race_game_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : race_game_ctrl_if
// Purpose  : Button inputs and position/status outputs of the game controller.
//            The controller takes the master modport; renderer/driver the slave.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface race_game_ctrl_if;

  logic       left_i;
  logic       right_i;
  logic [9:0] player_x_o;
  logic [9:0] player_y_o;
  logic [9:0] enemy_x_o;
  logic [9:0] enemy_y_o;
  logic [7:0] score_o;
  logic       crash_o;
  logic       playing_o;

  modport master (
    input  left_i, right_i,
    output player_x_o, player_y_o, enemy_x_o, enemy_y_o,
    output score_o, crash_o, playing_o
  );

  modport slave (
    output left_i, right_i,
    input  player_x_o, player_y_o, enemy_x_o, enemy_y_o,
    input  score_o, crash_o, playing_o
  );

endinterface

`default_nettype wire

// File: rtl/race_lfsr8.sv
//------------------------------------------------------------------------------
// Module   : race_lfsr8
// Purpose  : Seeded 8-bit Fibonacci LFSR (taps 7,5,4,3), advances every tick.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module race_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       logic_clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

  always_ff @(posedge logic_clk) begin
    if (reset) begin
      r_q <= SEED;
    end else begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/race_game_ctrl.sv
//------------------------------------------------------------------------------
// Module   : race_game_ctrl
// Purpose  : Racing-game logic: lane moves, enemy motion/respawn, collision, score.
//            Optional macro RACE_SPEEDUP_EN raises the enemy step with the score.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module race_game_ctrl
  import race_pkg::*;
#(
  parameter int         STEP       = 8,
  parameter int         CRASH_HOLD = 20,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic             logic_clk,
  input  logic             reset,
  race_game_ctrl_if.master bus
);

  localparam int HOLD_W = $clog2(CRASH_HOLD + 1);

  race_state_t       r_state;
  logic [9:0]        r_player_x;
  logic [9:0]        r_enemy_x;
  logic [9:0]        r_enemy_y;
  logic [7:0]        r_score;
  logic              r_crash;
  logic              r_playing;
  logic              r_left_q;
  logic              r_right_q;
  logic [HOLD_W-1:0] r_hold;

  logic [7:0]  w_lfsr;
  logic        w_lfsr_unused;
  logic        w_press_l;
  logic        w_press_r;
  logic        w_press_any;
  logic        w_collide;
  logic        w_wrap;
  logic [10:0] w_step;
  logic [10:0] w_enemy_next;
  logic [9:0]  w_lane_next;

  race_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .logic_clk (logic_clk),
    .reset     (reset),
    .q         (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[7:2];

  assign w_press_l   = bus.left_i  & ~r_left_q;
  assign w_press_r   = bus.right_i & ~r_right_q;
  assign w_press_any = w_press_l | w_press_r;

  // Vertical overlap test done in 11 bits so enemy_y + CAR_H cannot wrap.
  assign w_collide = (r_enemy_x == r_player_x) &&
                     (({1'b0, r_enemy_y} + {1'b0, CAR_H}) > {1'b0, PLAYER_Y}) &&
                     ({1'b0, r_enemy_y} < ({1'b0, PLAYER_Y} + {1'b0, CAR_H}));

`ifdef RACE_SPEEDUP_EN
  logic [10:0] w_boost;
  always_comb begin
    w_boost = 11'(STEP) + 11'(r_score >> 3);
    w_step  = (w_boost > 11'd16) ? 11'd16 : w_boost;
  end
`else
  assign w_step = 11'(STEP);
`endif

  assign w_enemy_next = {1'b0, r_enemy_y} + w_step;
  assign w_wrap       = (w_enemy_next >= {1'b0, SCREEN_H});

  always_comb begin
    w_lane_next = r_player_x;
    if (w_press_l && !w_press_r) begin
      w_lane_next = (r_player_x == LANE_R) ? LANE_C : LANE_L;
    end else if (w_press_r && !w_press_l) begin
      w_lane_next = (r_player_x == LANE_L) ? LANE_C : LANE_R;
    end
  end

  always_ff @(posedge logic_clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_player_x <= LANE_C;
      r_enemy_x  <= LANE_L;
      r_enemy_y  <= '0;
      r_score    <= '0;
      r_crash    <= 1'b0;
      r_playing  <= 1'b0;
      r_left_q   <= 1'b0;
      r_right_q  <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_left_q  <= bus.left_i;
      r_right_q <= bus.right_i;
      case (r_state)
        IDLE: begin
          if (w_press_any) begin
            r_state   <= PLAY;
            r_playing <= 1'b1;
          end
        end
        PLAY: begin
          if (w_collide) begin
            r_state   <= CRASH;
            r_playing <= 1'b0;
            r_crash   <= 1'b1;
            r_hold    <= HOLD_W'(CRASH_HOLD);
          end else begin
            r_player_x <= w_lane_next;
            if (w_wrap) begin
              r_enemy_y <= '0;
              r_enemy_x <= lane_from_rand(w_lfsr[1:0]);
              if (r_score != 8'hFF) begin
                r_score <= r_score + 8'd1;
              end
            end else begin
              r_enemy_y <= w_enemy_next[9:0];
            end
          end
        end
        CRASH: begin
          if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_W'(1);
          end else if (w_press_any) begin
            r_state    <= IDLE;
            r_crash    <= 1'b0;
            r_player_x <= LANE_C;
            r_enemy_x  <= LANE_L;
            r_enemy_y  <= '0;
            r_score    <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_crash   <= 1'b0;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.player_x_o = r_player_x;
  assign bus.player_y_o = PLAYER_Y;
  assign bus.enemy_x_o  = r_enemy_x;
  assign bus.enemy_y_o  = r_enemy_y;
  assign bus.score_o    = r_score;
  assign bus.crash_o    = r_crash;
  assign bus.playing_o  = r_playing;

endmodule

`default_nettype wire
